// File: rtl/dir_req_arbiter.sv
// Round-robin arbiter/sequencer that shares one directory request port among
// N_CORES requesters. One transaction is in flight at a time: grant, issue
// with valid/ready, wait for the response (or a watchdog timeout), route the
// result back to the owning core.
module dir_req_arbiter #(
    parameter int WIDTH   = 32,
    parameter int N_CORES = 4,
    parameter int SRC_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [N_CORES-1:0]         core_req_valid,
    input  logic [N_CORES-1:0]         core_req_write,
    input  logic [N_CORES*WIDTH-1:0]   core_req_addr,
    input  logic [N_CORES*WIDTH-1:0]   core_req_wdata,
    output logic [N_CORES-1:0]         core_req_ready,
    output logic [N_CORES-1:0]         core_resp_valid,
    output logic [WIDTH-1:0]           core_resp_data,
    output logic                       core_resp_err,
    output logic                       dir_req_valid,
    input  logic                       dir_req_ready,
    output logic                       dir_req_write,
    output logic [WIDTH-1:0]           dir_req_addr,
    output logic [WIDTH-1:0]           dir_req_wdata,
    output logic [SRC_W-1:0]           dir_req_src,
    input  logic                       dir_resp_valid,
    input  logic [WIDTH-1:0]           dir_resp_data,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    localparam logic [15:0]      TIMER_LAST = 16'(TIMEOUT - 1);
    localparam logic [SRC_W-1:0] LAST_CORE  = SRC_W'(N_CORES - 1);

    state_t             state;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   owner;
    logic [15:0]        timer;

    logic [WIDTH-1:0]   addr_arr  [N_CORES];
    logic [WIDTH-1:0]   wdata_arr [N_CORES];

    logic               found;
    logic [SRC_W-1:0]   sel;
    logic               sel_write;
    logic [WIDTH-1:0]   sel_addr;
    logic [WIDTH-1:0]   sel_wdata;
    logic [SRC_W-1:0]   next_ptr;

    // Unpack the flat address/data buses into per-core arrays
    for (genvar g = 0; g < N_CORES; g++) begin : g_unpack
        assign addr_arr[g]  = core_req_addr[g*WIDTH +: WIDTH];
        assign wdata_arr[g] = core_req_wdata[g*WIDTH +: WIDTH];
    end

    // Round-robin pick: first pending core scanning upward from rr_ptr, wrapping
    always_comb begin : pick
        logic [SRC_W:0]   sum;
        logic [SRC_W-1:0] idx;
        found     = 1'b0;
        sel       = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sum       = '0;
        idx       = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            sum = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (sum >= (SRC_W+1)'(N_CORES)) begin
                sum = sum - (SRC_W+1)'(N_CORES);
            end
            idx = sum[SRC_W-1:0];
            if (!found && core_req_valid[idx]) begin
                found     = 1'b1;
                sel       = idx;
                sel_write = core_req_write[idx];
                sel_addr  = addr_arr[idx];
                sel_wdata = wdata_arr[idx];
            end
        end
    end

    // Pointer value after the current owner completes
    always_comb begin
        next_ptr = (owner == LAST_CORE) ? '0 : owner + SRC_W'(1);
    end

    // Main sequencer: grant, issue, wait for response or timeout
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            owner           <= '0;
            timer           <= '0;
            core_req_ready  <= '0;
            core_resp_valid <= '0;
            core_resp_data  <= '0;
            core_resp_err   <= 1'b0;
            dir_req_valid   <= 1'b0;
            dir_req_write   <= 1'b0;
            dir_req_addr    <= '0;
            dir_req_wdata   <= '0;
            dir_req_src     <= '0;
            busy            <= 1'b0;
        end else begin
            core_req_ready  <= '0;
            core_resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner          <= sel;
                        dir_req_src    <= sel;
                        dir_req_write  <= sel_write;
                        dir_req_addr   <= sel_addr;
                        dir_req_wdata  <= sel_wdata;
                        core_req_ready <= N_CORES'(1) << sel;
                        dir_req_valid  <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dir_req_ready) begin
                        dir_req_valid <= 1'b0;
                        timer         <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + 16'd1;
                    // A response on the timeout cycle takes priority over the error
                    if (dir_resp_valid) begin
                        core_resp_data  <= dir_resp_data;
                        core_resp_err   <= 1'b0;
                        core_resp_valid <= N_CORES'(1) << owner;
                        rr_ptr          <= next_ptr;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        core_resp_data  <= '0;
                        core_resp_err   <= 1'b1;
                        core_resp_valid <= N_CORES'(1) << owner;
                        rr_ptr          <= next_ptr;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dir_req_arbiter.sv
// Directed bench for dir_req_arbiter: expected grants and responses are queued
// as stimulus is driven and checked by a monitor when the DUT emits them.
module tb_dir_req_arbiter;

    localparam int WIDTH   = 32;
    localparam int N       = 4;
    localparam int SRC_W   = 2;
    localparam int TIMEOUT = 8;

    logic                  sys_clk = 1'b0;
    logic                  sys_rst = 1'b1;
    logic [N-1:0]          core_req_valid = '0;
    logic [N-1:0]          core_req_write = '0;
    logic [N*WIDTH-1:0]    core_req_addr  = '0;
    logic [N*WIDTH-1:0]    core_req_wdata = '0;
    logic [N-1:0]          core_req_ready;
    logic [N-1:0]          core_resp_valid;
    logic [WIDTH-1:0]      core_resp_data;
    logic                  core_resp_err;
    logic                  dir_req_valid;
    logic                  dir_req_ready = 1'b0;
    logic                  dir_req_write;
    logic [WIDTH-1:0]      dir_req_addr;
    logic [WIDTH-1:0]      dir_req_wdata;
    logic [SRC_W-1:0]      dir_req_src;
    logic                  dir_resp_valid = 1'b0;
    logic [WIDTH-1:0]      dir_resp_data  = '0;
    logic                  busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          core;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        int          core;
        logic [31:0] data;
        logic        err;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];

    dir_req_arbiter #(
        .WIDTH   (WIDTH),
        .N_CORES (N),
        .SRC_W   (SRC_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .core_req_valid  (core_req_valid),
        .core_req_write  (core_req_write),
        .core_req_addr   (core_req_addr),
        .core_req_wdata  (core_req_wdata),
        .core_req_ready  (core_req_ready),
        .core_resp_valid (core_resp_valid),
        .core_resp_data  (core_resp_data),
        .core_resp_err   (core_resp_err),
        .dir_req_valid   (dir_req_valid),
        .dir_req_ready   (dir_req_ready),
        .dir_req_write   (dir_req_write),
        .dir_req_addr    (dir_req_addr),
        .dir_req_wdata   (dir_req_wdata),
        .dir_req_src     (dir_req_src),
        .dir_resp_valid  (dir_resp_valid),
        .dir_resp_data   (dir_resp_data),
        .busy            (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "simulation watchdog expired");
    end

    function automatic logic [N-1:0] onehot(input int c);
        logic [N-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int c, input logic w, input logic [31:0] a, input logic [31:0] d);
        core_req_valid[c]               = 1'b1;
        core_req_write[c]               = w;
        core_req_addr[c*WIDTH +: WIDTH]  = a;
        core_req_wdata[c*WIDTH +: WIDTH] = d;
    endtask

    task automatic push_grant(input int c, input logic w, input logic [31:0] a, input logic [31:0] d);
        grant_t g;
        g.core = c; g.write = w; g.addr = a; g.wdata = d;
        grant_q.push_back(g);
    endtask

    task automatic push_resp(input int c, input logic [31:0] d, input logic e);
        resp_t r;
        r.core = c; r.data = d; r.err = e;
        resp_q.push_back(r);
    endtask

    // Advance to the first negedge where a request is being issued (bounded)
    task automatic wait_issue();
        for (int j = 0; j < 20; j++) begin
            @(negedge sys_clk);
            if (dir_req_valid) break;
        end
        check("issue_seen", 64'(dir_req_valid), 64'd1);
    endtask

    task automatic accept();
        dir_req_ready = 1'b1;
        @(negedge sys_clk);
        dir_req_ready = 1'b0;
    endtask

    task automatic respond(input int delay, input logic [31:0] d, input int owner);
        repeat (delay) @(negedge sys_clk);
        dir_resp_data  = d;
        dir_resp_valid = 1'b1;
        push_resp(owner, d, 1'b0);
        @(negedge sys_clk);
        dir_resp_valid = 1'b0;
        dir_resp_data  = '0;
    endtask

    // Monitor: compare every grant and response pulse against the scoreboard
    always @(posedge sys_clk) begin : monitor
        grant_t g;
        resp_t  r;
        #1;
        if (!sys_rst && core_req_ready != '0) begin
            if (grant_q.size() == 0) begin
                check("unexpected_grant", 64'(core_req_ready), 64'd0);
            end else begin
                g = grant_q.pop_front();
                check("grant_ready", 64'(core_req_ready), 64'(onehot(g.core)));
                check("grant_src",   64'(dir_req_src),    64'(g.core));
                check("grant_valid", 64'(dir_req_valid),  64'd1);
                check("grant_write", 64'(dir_req_write),  64'(g.write));
                check("grant_addr",  64'(dir_req_addr),   64'(g.addr));
                check("grant_wdata", 64'(dir_req_wdata),  64'(g.wdata));
            end
        end
        if (!sys_rst && core_resp_valid != '0) begin
            if (resp_q.size() == 0) begin
                check("unexpected_resp", 64'(core_resp_valid), 64'd0);
            end else begin
                r = resp_q.pop_front();
                check("resp_valid", 64'(core_resp_valid), 64'(onehot(r.core)));
                check("resp_data",  64'(core_resp_data),  64'(r.data));
                check("resp_err",   64'(core_resp_err),   64'(r.err));
            end
        end
    end

    initial begin : stimulus
        int order [6];
        int cnt;
        order = '{0, 1, 3, 0, 1, 3};

        // Reset state
        repeat (2) @(negedge sys_clk);
        check("rst_dir_valid", 64'(dir_req_valid),   64'd0);
        check("rst_busy",      64'(busy),            64'd0);
        check("rst_ready",     64'(core_req_ready),  64'd0);
        check("rst_resp",      64'(core_resp_valid), 64'd0);
        check("rst_src",       64'(dir_req_src),     64'd0);
        check("rst_err",       64'(core_resp_err),   64'd0);
        sys_rst = 1'b0;

        // Round robin among cores 0,1,3 requesting continuously
        set_req(0, 1'b0, 32'h0000_1000, 32'h0);
        set_req(1, 1'b0, 32'h0000_1100, 32'h0);
        set_req(3, 1'b0, 32'h0000_1300, 32'h0);
        for (int k = 0; k < 6; k++) begin
            push_grant(order[k], 1'b0, 32'h0000_1000 + 32'(order[k]) * 32'h100, 32'h0);
        end
        for (int k = 0; k < 6; k++) begin
            wait_issue();
            if (k == 5) core_req_valid = '0;
            accept();
            respond(1, 32'hA000_0000 + 32'(k), order[k]);
        end
        repeat (3) @(negedge sys_clk);
        check("rr_idle_busy", 64'(busy), 64'd0);

        // Single load from core 2
        set_req(2, 1'b0, 32'h0000_0040, 32'h0);
        push_grant(2, 1'b0, 32'h0000_0040, 32'h0);
        wait_issue();
        core_req_valid[2] = 1'b0;
        accept();
        check("ready_one_cycle", 64'(core_req_ready), 64'd0);
        respond(3, 32'hDEAD_BEEF, 2);
        check("load_busy_low",  64'(busy),           64'd0);
        check("load_data_hold", 64'(core_resp_data), 64'hDEAD_BEEF);

        // Store from core 1 with directory stalling ready for 5 cycles
        set_req(1, 1'b1, 32'h0000_0100, 32'h1234_5678);
        push_grant(1, 1'b1, 32'h0000_0100, 32'h1234_5678);
        wait_issue();
        core_req_valid[1] = 1'b0;
        for (int j = 0; j < 6; j++) begin
            check("st_valid", 64'(dir_req_valid), 64'd1);
            check("st_addr",  64'(dir_req_addr),  64'h100);
            check("st_wdata", 64'(dir_req_wdata), 64'h1234_5678);
            check("st_write", 64'(dir_req_write), 64'd1);
            check("st_src",   64'(dir_req_src),   64'd1);
            if (j < 5) @(negedge sys_clk);
        end
        accept();
        check("st_valid_drop", 64'(dir_req_valid), 64'd0);
        respond(2, 32'h0000_0ACE, 1);

        // Timeout on core 2, then core 0 (still pending) gets the port
        @(negedge sys_clk);
        set_req(2, 1'b0, 32'h0000_0200, 32'h0);
        set_req(0, 1'b1, 32'h0000_0300, 32'h0000_CAFE);
        push_grant(2, 1'b0, 32'h0000_0200, 32'h0);
        push_grant(0, 1'b1, 32'h0000_0300, 32'h0000_CAFE);
        wait_issue();
        core_req_valid[2] = 1'b0;
        accept();
        push_resp(2, 32'h0, 1'b1);
        cnt = 0;
        for (int j = 0; j < 40; j++) begin
            if (core_resp_valid != '0) break;
            cnt++;
            @(negedge sys_clk);
        end
        check("wait_cycles", 64'(cnt), 64'(TIMEOUT));
        check("to_err_flag", 64'(core_resp_err), 64'd1);

        // Response arriving on the timeout edge wins
        wait_issue();
        core_req_valid[0] = 1'b0;
        accept();
        respond(TIMEOUT - 1, 32'h0000_0055, 0);
        check("race_err",  64'(core_resp_err),  64'd0);
        check("race_data", 64'(core_resp_data), 64'h55);

        // Spurious directory response while idle
        @(negedge sys_clk);
        dir_resp_data  = 32'h0000_0099;
        dir_resp_valid = 1'b1;
        @(negedge sys_clk);
        dir_resp_valid = 1'b0;
        dir_resp_data  = '0;
        check("spur_resp",  64'(core_resp_valid), 64'd0);
        check("spur_busy",  64'(busy),            64'd0);
        check("spur_hold",  64'(core_resp_data),  64'h55);
        @(negedge sys_clk);
        check("spur_resp2", 64'(core_resp_valid), 64'd0);

        // Reset during WAIT aborts the transaction
        set_req(1, 1'b1, 32'h0000_0400, 32'h0000_4444);
        push_grant(1, 1'b1, 32'h0000_0400, 32'h0000_4444);
        wait_issue();
        core_req_valid[1] = 1'b0;
        accept();
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check("arst_busy",  64'(busy),            64'd0);
        check("arst_addr",  64'(dir_req_addr),    64'd0);
        check("arst_wdata", 64'(dir_req_wdata),   64'd0);
        check("arst_write", 64'(dir_req_write),   64'd0);
        check("arst_src",   64'(dir_req_src),     64'd0);
        check("arst_data",  64'(core_resp_data),  64'd0);
        check("arst_resp",  64'(core_resp_valid), 64'd0);
        set_req(0, 1'b0, 32'h0000_0500, 32'h0);
        set_req(3, 1'b0, 32'h0000_0530, 32'h0);
        repeat (2) @(negedge sys_clk);
        check("arst_no_resp", 64'(core_resp_valid), 64'd0);
        push_grant(0, 1'b0, 32'h0000_0500, 32'h0);
        push_grant(3, 1'b0, 32'h0000_0530, 32'h0);
        sys_rst = 1'b0;
        wait_issue();
        core_req_valid[0] = 1'b0;
        accept();
        respond(1, 32'h0000_0077, 0);
        wait_issue();
        core_req_valid[3] = 1'b0;
        accept();
        respond(1, 32'h0000_0078, 3);

        repeat (4) @(negedge sys_clk);
        check("grant_q_empty", 64'(grant_q.size()), 64'd0);
        check("resp_q_empty",  64'(resp_q.size()),  64'd0);
        check("final_busy",    64'(busy),           64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dir_req_arbiter.md
Name: dir_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one directory/L2 request port among N_CORES core-side request generators in the MESI directory system.
- Latches one core's load/store request and issues it to the directory with a valid/ready handshake.
- Waits for the directory response and routes it back to the owning core.
- A watchdog terminates any transaction that does not receive a response, returning an error to the owner.

Parameters:
- WIDTH, 32, address/data width
- N_CORES, 4, number of requesters (2..8)
- SRC_W, 2, width of core index; must equal ceil(log2(N_CORES))
- TIMEOUT, 255, cycles in WAIT before the error response (1..65535)

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  asynchronous, active-high reset
- core_req_valid  in  N_CORES  per-core request pending, level; held until core_req_ready
- core_req_write  in  N_CORES  1 = store, 0 = load
- core_req_addr  in  N_CORES*WIDTH  packed addresses, core i at [i*WIDTH +: WIDTH]
- core_req_wdata  in  N_CORES*WIDTH  packed store data
- core_req_ready  out  N_CORES  one-cycle accept pulse to the granted core
- core_resp_valid  out  N_CORES  one-cycle response pulse to the owner
- core_resp_data  out  WIDTH  load data, shared, valid with core_resp_valid
- core_resp_err  out  1  timeout flag, valid with core_resp_valid
- dir_req_valid  out  1  request to directory
- dir_req_ready  in  1  directory accepts when valid&&ready
- dir_req_write  out  1  latched write flag
- dir_req_addr  out  WIDTH  latched address
- dir_req_wdata  out  WIDTH  latched store data
- dir_req_src  out  SRC_W  owner core index
- dir_resp_valid  in  1  directory response strobe
- dir_resp_data  in  WIDTH  response data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset, asynchronous: all outputs 0, state=IDLE, rr_ptr=0, timer=0, owner=0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any core_req_valid bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... mod N_CORES.
  - Latch that core's write/addr/wdata into the dir_req_* registers and set owner and dir_req_src to the selected index.
  - Pulse core_req_ready[sel] and drive dir_req_valid=1 in the next cycle; go to ISSUE.
  - Latency: request visible at edge t produces accept and dir_req_valid at t+1.
- ISSUE:
  - dir_req_valid stays high; all dir_req_* fields are stable and ignore further core inputs.
  - On the edge where dir_req_ready=1: drop dir_req_valid, clear timer, go to WAIT.
  - No timeout applies in ISSUE; the block may stall indefinitely.
- WAIT:
  - timer increments each cycle.
  - On dir_resp_valid: core_resp_data<=dir_resp_data, core_resp_err<=0, pulse core_resp_valid[owner], rr_ptr<=(owner+1) mod N_CORES, go to IDLE.
  - If timer reaches TIMEOUT-1 without a response: core_resp_data<=0, core_resp_err<=1, pulse core_resp_valid[owner], update rr_ptr as above, go to IDLE.
  - If dir_resp_valid arrives in the same cycle as the timeout, the response wins (err=0).
- Stores also wait for dir_resp_valid as a write acknowledgement; data is passed through unchanged.
- dir_resp_valid in IDLE or ISSUE is ignored, with no output effect.
- core_resp_err and core_resp_data hold their values until the next response; core_resp_valid is a single-cycle pulse.
- A new grant cannot occur in the same cycle as a response: IDLE is entered first, so the minimum spacing between grants is 3 cycles plus directory latency.
- rr_ptr wraps N_CORES-1 -> 0.
- A core's deassertion of core_req_valid after being latched has no effect.
- Reset mid-transaction aborts it: no response is generated and all outputs clear immediately.

Test Plan:
- Single load, core 2, addr 0x0000_0040; dir_req_ready=1 immediately, response 0xDEAD_BEEF after 3 cycles -> core_req_ready=0b0100 one cycle; dir_req_src=2; core_resp_valid=0b0100 with data 0xDEAD_BEEF, err=0; busy returns low.
- Cores 0,1,3 all request continuously, each response after 1 cycle -> grant order 0,1,3,0,1,3; no core is granted twice consecutively while others wait.
- Store from core 1, addr 0x100, wdata 0x1234_5678; dir_req_ready held low 5 cycles -> dir_req_valid and fields stable for all 6 cycles; single accept; ack pulse core_resp_valid=0b0010.
- No response, TIMEOUT=8 -> exactly 8 cycles in WAIT, then core_resp_valid[owner]=1, err=1, data=0; the next pending core is granted afterwards.
- dir_resp_valid arriving on the timeout cycle with data 0x55 -> err=0, data=0x55; spurious dir_resp_valid in IDLE -> no core_resp_valid.
- Assert sys_rst during WAIT -> all outputs 0 asynchronously, no response pulse; after release, rr_ptr=0 and core 0 is granted first when cores 0 and 3 both request.
